// File: rtl/fpu_out_pkg.sv
// fpu_out_sched shared definitions
// pipe indices, dest_rdy positions, ID field split
package fpu_out_pkg;

  localparam int PIPE_ADD = 0;
  localparam int PIPE_MUL = 1;
  localparam int PIPE_DIV = 2;
  localparam int NPIPE    = 3;

  localparam int DEST_ADD = PIPE_ADD;
  localparam int DEST_MUL = PIPE_MUL;
  localparam int DEST_DIV = PIPE_DIV;

  localparam int CQ_LSB = 2;
  localparam int CQ_W   = 8;
  localparam int THR_W  = 2;

  typedef enum logic [1:0] {
    WIN_ADD  = 2'd0,
    WIN_MUL  = 2'd1,
    WIN_DIV  = 2'd2,
    WIN_NONE = 2'd3
  } win_e;

  function automatic logic [NPIPE-1:0] win_onehot(win_e w);
    logic [NPIPE-1:0] v;
    v = '0;
    if (w != WIN_NONE) v[w] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fpu_out_fifo.sv
// fpu_out_fifo: small per-pipe result queue
// a push into a full queue without a pop is dropped
module fpu_out_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign head   = r_mem[r_rd];
  assign count  = r_cnt;

  // storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // pointers wrap naturally with power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/fpu_out_sched.sv
// fpu_out_sched: FPU result scheduler toward CPX
// div priority, add/mul round robin, credit flow control
module fpu_out_sched
  import fpu_out_pkg::*;
#(
  parameter int QDEPTH  = 2,
  parameter int CREDITS = 2,
  parameter int ID_W    = 10
) (
  input  logic            rclk,
  input  logic            arst,
  input  logic            div_req_in,
  input  logic            mul_req_in,
  input  logic            add_req_in,
  input  logic [ID_W-1:0] div_id_in,
  input  logic [ID_W-1:0] mul_id_in,
  input  logic [ID_W-1:0] add_id_in,
  input  logic            cpx_fp_crd_ret,
  output logic [7:0]      fp_cpx_req_cq,
  output logic [1:0]      req_thread,
  output logic [2:0]      dest_rdy,
  output logic            div_hold,
  output logic            mul_hold,
  output logic            add_hold,
  output logic [2:0]      credit_cnt,
  output logic [1:0]      err
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ID_W-1:0] w_id   [NPIPE];
  logic [ID_W-1:0] w_head [NPIPE];
  logic [CW-1:0]   w_cnt  [NPIPE];
  logic [NPIPE-1:0] w_req, w_full, w_empty, w_pop, w_ovf, w_hnx;

  win_e            w_win;
  logic            w_issue;
  logic [ID_W-1:0] w_sel;
  logic            w_ret_ok;
  logic [2:0]      w_crd_nxt;

  logic [7:0]       r_cq;
  logic [1:0]       r_thr;
  logic [2:0]       r_dest;
  logic [NPIPE-1:0] r_hold;
  logic [2:0]       r_crd;
  logic [1:0]       r_err;
  logic             r_add_turn;

  assign w_req[PIPE_ADD] = add_req_in;
  assign w_req[PIPE_MUL] = mul_req_in;
  assign w_req[PIPE_DIV] = div_req_in;
  assign w_id[PIPE_ADD]  = add_id_in;
  assign w_id[PIPE_MUL]  = mul_id_in;
  assign w_id[PIPE_DIV]  = div_id_in;

  for (genvar g = 0; g < NPIPE; g++) begin : g_q
    assign w_pop[g] = (w_win == win_e'(g));
    assign w_ovf[g] = w_req[g] && w_full[g] && !w_pop[g];
    assign w_hnx[g] =
      (CW'(w_cnt[g] + CW'(w_req[g] && !w_ovf[g]) - CW'(w_pop[g]))
       >= CW'(QDEPTH - 1));

    fpu_out_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (ID_W)
    ) u_fifo (
      .clk   (rclk),
      .rst   (arst),
      .push  (w_req[g]),
      .pop   (w_pop[g]),
      .din   (w_id[g]),
      .head  (w_head[g]),
      .count (w_cnt[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
  end

  // winner pick: div first, then add/mul by add_turn
  always_comb begin
    w_win = WIN_NONE;
    w_sel = '0;
    if (r_crd != '0) begin
      priority case (1'b1)
        !w_empty[PIPE_DIV]:
          w_win = WIN_DIV;
        !w_empty[PIPE_MUL] && !w_empty[PIPE_ADD]:
          w_win = r_add_turn ? WIN_ADD : WIN_MUL;
        !w_empty[PIPE_MUL]:
          w_win = WIN_MUL;
        !w_empty[PIPE_ADD]:
          w_win = WIN_ADD;
        default:
          w_win = WIN_NONE;
      endcase
    end
    unique case (w_win)
      WIN_ADD: w_sel = w_head[PIPE_ADD];
      WIN_MUL: w_sel = w_head[PIPE_MUL];
      WIN_DIV: w_sel = w_head[PIPE_DIV];
      default: w_sel = '0;
    endcase
  end

  assign w_issue  = (w_win != WIN_NONE);
  assign w_ret_ok = cpx_fp_crd_ret &&
                    !(r_crd == 3'(CREDITS) && !w_issue);
  assign w_crd_nxt = r_crd - 3'(w_issue) + 3'(w_ret_ok);

  // issue registers, credits, arbitration turn, sticky errors
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      r_cq       <= '0;
      r_thr      <= '0;
      r_dest     <= '0;
      r_hold     <= '0;
      r_crd      <= 3'(CREDITS);
      r_err      <= '0;
      r_add_turn <= 1'b0;
    end else begin
      r_cq   <= w_issue ? 8'(w_sel[ID_W-1:CQ_LSB]) : '0;
      r_thr  <= w_issue ? w_sel[THR_W-1:0] : '0;
      r_dest <= win_onehot(w_win);
      r_hold <= w_hnx;
      r_crd  <= w_crd_nxt;
      if (|w_ovf) r_err[0] <= 1'b1;
      if (cpx_fp_crd_ret && !w_ret_ok) r_err[1] <= 1'b1;
      if (w_issue && w_win != WIN_DIV) r_add_turn <= !r_add_turn;
    end
  end

  assign fp_cpx_req_cq = r_cq;
  assign req_thread    = r_thr;
  assign dest_rdy      = r_dest;
  assign div_hold      = r_hold[PIPE_DIV];
  assign mul_hold      = r_hold[PIPE_MUL];
  assign add_hold      = r_hold[PIPE_ADD];
  assign credit_cnt    = r_crd;
  assign err           = r_err;

endmodule

// File: tb/tb_fpu_out_sched.sv
// tb_fpu_out_sched: random + directed bench
// queue-based reference model of the scheduler
module tb_fpu_out_sched;

  localparam int QDEPTH  = 2;
  localparam int CREDITS = 2;
  localparam int ID_W    = 10;

  logic            rclk = 1'b0;
  logic            arst;
  logic            div_req_in, mul_req_in, add_req_in;
  logic [ID_W-1:0] div_id_in, mul_id_in, add_id_in;
  logic            cpx_fp_crd_ret;
  logic [7:0]      fp_cpx_req_cq;
  logic [1:0]      req_thread;
  logic [2:0]      dest_rdy;
  logic            div_hold, mul_hold, add_hold;
  logic [2:0]      credit_cnt;
  logic [1:0]      err;

  fpu_out_sched #(
    .QDEPTH  (QDEPTH),
    .CREDITS (CREDITS),
    .ID_W    (ID_W)
  ) dut (
    .rclk           (rclk),
    .arst           (arst),
    .div_req_in     (div_req_in),
    .mul_req_in     (mul_req_in),
    .add_req_in     (add_req_in),
    .div_id_in      (div_id_in),
    .mul_id_in      (mul_id_in),
    .add_id_in      (add_id_in),
    .cpx_fp_crd_ret (cpx_fp_crd_ret),
    .fp_cpx_req_cq  (fp_cpx_req_cq),
    .req_thread     (req_thread),
    .dest_rdy       (dest_rdy),
    .div_hold       (div_hold),
    .mul_hold       (mul_hold),
    .add_hold       (add_hold),
    .credit_cnt     (credit_cnt),
    .err            (err)
  );

  always #5 rclk = ~rclk;

  int n_vec = 0;
  int n_err = 0;

  logic [ID_W-1:0] qa[$], qm[$], qd[$];
  int         m_crd;
  bit         m_turn;
  logic [1:0] m_err;
  logic [7:0] e_cq;
  logic [1:0] e_thr;
  logic [2:0] e_dest;
  logic [2:0] e_hold;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qm.delete(); qd.delete();
    m_crd = CREDITS; m_turn = 0; m_err = '0;
    e_cq = '0; e_thr = '0; e_dest = '0; e_hold = '0;
  endtask

  task automatic model_edge();
    int win;
    bit iss;
    logic [ID_W-1:0] id;
    win = -1;
    id = '0;
    if (m_crd > 0) begin
      if (qd.size() > 0) win = 2;
      else if (qm.size() > 0 && qa.size() > 0) win = m_turn ? 0 : 1;
      else if (qm.size() > 0) win = 1;
      else if (qa.size() > 0) win = 0;
    end
    iss = (win >= 0);
    case (win)
      0: id = qa.pop_front();
      1: id = qm.pop_front();
      2: id = qd.pop_front();
      default: id = '0;
    endcase
    e_cq   = iss ? 8'(id >> 2) : 8'h0;
    e_thr  = iss ? 2'(id) : 2'h0;
    e_dest = iss ? 3'(1 << win) : 3'h0;
    if (iss && win != 2) m_turn = !m_turn;
    if (add_req_in) begin
      if (qa.size() == QDEPTH) m_err[0] = 1'b1;
      else qa.push_back(add_id_in);
    end
    if (mul_req_in) begin
      if (qm.size() == QDEPTH) m_err[0] = 1'b1;
      else qm.push_back(mul_id_in);
    end
    if (div_req_in) begin
      if (qd.size() == QDEPTH) m_err[0] = 1'b1;
      else qd.push_back(div_id_in);
    end
    if (cpx_fp_crd_ret && !iss && m_crd == CREDITS) m_err[1] = 1'b1;
    else m_crd = m_crd - int'(iss) + int'(cpx_fp_crd_ret);
    e_hold = {qd.size() >= QDEPTH - 1,
              qm.size() >= QDEPTH - 1,
              qa.size() >= QDEPTH - 1};
  endtask

  task automatic check_all();
    chk("cq",    32'(fp_cpx_req_cq), 32'(e_cq));
    chk("thr",   32'(req_thread),    32'(e_thr));
    chk("dest",  32'(dest_rdy),      32'(e_dest));
    chk("hold",  32'({div_hold, mul_hold, add_hold}), 32'(e_hold));
    chk("crd",   32'(credit_cnt),    32'(m_crd));
    chk("err",   32'(err),           32'(m_err));
  endtask

  task automatic drv(bit d, bit m, bit a,
                     logic [ID_W-1:0] di, logic [ID_W-1:0] mi,
                     logic [ID_W-1:0] ai, bit ret);
    div_req_in = d; mul_req_in = m; add_req_in = a;
    div_id_in = di; mul_id_in = mi; add_id_in = ai;
    cpx_fp_crd_ret = ret;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge rclk);
    @(negedge rclk);
    check_all();
  endtask

  task automatic do_reset();
    drv(0, 0, 0, '0, '0, '0, 0);
    arst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge rclk);
    arst = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    drv(0, 0, 0, '0, '0, '0, 0);
    model_reset();
    repeat (2) @(negedge rclk);
    check_all();
    arst = 1'b0;

    // single add request
    drv(0, 0, 1, '0, '0, 10'h3C6, 0);
    cycle();
    drv(0, 0, 0, '0, '0, '0, 0);
    cycle();
    chk("tp1_cq",   32'(fp_cpx_req_cq), 32'h0F1);
    chk("tp1_thr",  32'(req_thread),    32'd2);
    chk("tp1_dest", 32'(dest_rdy),      32'b001);
    chk("tp1_crd",  32'(credit_cnt),    32'd1);
    drv(0, 0, 0, '0, '0, '0, 1);
    cycle();

    // mul/add streaming, mul first
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drv(0, !mul_hold, !add_hold, '0,
          ID_W'($urandom), ID_W'($urandom), i > 0);
      cycle();
      if (i == 1) chk("rr_first", 32'(dest_rdy), 32'b010);
      if (i == 2) chk("rr_second", 32'(dest_rdy), 32'b001);
    end

    // all three at once: div, mul, add
    do_reset();
    drv(1, 1, 1, 10'h111, 10'h222, 10'h333, 0);
    cycle();
    drv(0, 0, 0, '0, '0, '0, 0);
    cycle();
    chk("ord_div", 32'(dest_rdy), 32'b100);
    drv(0, 0, 0, '0, '0, '0, 1);
    cycle();
    chk("ord_mul", 32'(dest_rdy), 32'b010);
    cycle();
    chk("ord_add", 32'(dest_rdy), 32'b001);
    cycle();

    // credit exhaustion and overflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 1, '0, '0, ID_W'(10'h040 + i), 0);
      cycle();
      if (i == 0) chk("ovf_hold", 32'(add_hold), 32'd1);
    end
    chk("ovf_err0", 32'(err[0]), 32'd1);
    chk("ovf_crd0", 32'(credit_cnt), 32'd0);
    drv(0, 0, 0, '0, '0, '0, 1);
    cycle();
    chk("stall_dest", 32'(dest_rdy), 32'b000);
    drv(0, 0, 0, '0, '0, '0, 0);
    cycle();
    chk("resume_dest", 32'(dest_rdy), 32'b001);
    drv(0, 1, 0, '0, 10'h155, '0, 0);
    cycle();

    // reset with queued entries and no credit
    do_reset();
    chk("rst_crd", 32'(credit_cnt), 32'd2);
    chk("rst_dest", 32'(dest_rdy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_idle", 32'(dest_rdy), 32'd0);
    end

    // credit over-return
    do_reset();
    drv(0, 0, 0, '0, '0, '0, 1);
    cycle();
    chk("over_crd", 32'(credit_cnt), 32'd2);
    chk("over_err", 32'(err), 32'b10);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit d, m, a;
      d = ($urandom_range(0, 3) == 0) && (!div_hold || $urandom_range(0, 9) == 0);
      m = ($urandom_range(0, 1) == 0) && (!mul_hold || $urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 1) == 0) && (!add_hold || $urandom_range(0, 9) == 0);
      drv(d, m, a, ID_W'($urandom), ID_W'($urandom),
          ID_W'($urandom), $urandom_range(0, 9) < 4);
      cycle();
      if (i % 150 == 149) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
